image_loader: RTL
=================

Name: image_loader

Overview:
- Upstream stage of the skeletonization datapath. Accepts a raster-order stream of 8-bit grayscale pixels on a valid/ready handshake.
- Binarizes each pixel against a programmable threshold and forces the one-pixel image border to background.
- Issues write strobes, addresses and data into the image RAM port that feeds the mask stage.
- Signals frame completion so the mask stage can begin thinning.

Parameters:
- N, 8: image side length in pixels; frame = N*N pixels.
- bitSize, 6: RAM address MSB index; address width = bitSize+1; requires 2^(bitSize+1) >= N*N.
- BORDER_CLEAR, 1: 1 = pixels with row or col equal to 0 or N-1 are written as background; 0 = no forcing.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a frame load when idle.
- threshold  in  8  binarization threshold; sampled on the accepted start.
- s_valid  in  1  pixel stream valid.
- s_data  in  8  grayscale pixel.
- s_last  in  1  marks the final pixel of the frame.
- s_ready  out  1  loader accepts a pixel this cycle.
- mem_we  out  1  RAM write strobe.
- mem_addr  out  bitSize+1  RAM write address (raster index row*N+col).
- mem_data  out  8  binarized pixel: PIX_FG or PIX_BG.
- busy  out  1  state != IDLE.
- frame_done  out  1  one-cycle pulse at frame end.
- err  out  1  sticky framing error; cleared by the next accepted start.

Behaviour:
- Reset (async, immediate): state=IDLE; s_ready, mem_we, frame_done, busy, err = 0; mem_addr = 0; mem_data = 0; row, col and threshold registers = 0. A partial frame is discarded; no further writes occur.
- FSM states: IDLE, LOAD, DONE.
  - IDLE -> LOAD on start. Latch threshold, clear row/col/index, clear err.
  - LOAD -> DONE on the beat that is either the N*N-th accepted pixel or an accepted pixel with s_last=1.
  - DONE -> IDLE unconditionally after one cycle.
- start outside IDLE (during LOAD or DONE) is ignored.
- s_ready = (state == LOAD), combinational from state. It drops in the cycle after the final beat is accepted.
- Transfer occurs when s_valid & s_ready. With no transfer, counters hold and mem_we=0 next cycle.
- Write latency is one cycle, fully registered. In the cycle after a transfer:
  - mem_we = 1.
  - mem_addr = raster index of that beat.
  - mem_data = PIX_BG if BORDER_CLEAR and the beat is on the border; else PIX_FG if s_data >= threshold (unsigned, equality counts as foreground); else PIX_BG.
- Counters: col increments per beat and wraps N-1 -> 0 with row++. Index increments in lockstep. No wrap past N*N-1 is possible because the FSM leaves LOAD at that beat.
- frame_done is asserted in the DONE cycle, which coincides with the final mem_we pulse.
- Framing errors:
  - s_last on beat k < N*N-1: frame ends early (k+1 writes), err=1.
  - s_last absent on beat N*N-1: frame ends anyway (N*N writes), err=1.
  - s_last present exactly on beat N*N-1: err stays 0.
- busy = 1 in LOAD and DONE.
- Back-to-back frames: a start arriving in the IDLE cycle after DONE is accepted. Minimum frame period is N*N+2 cycles.

Decomposition:
- Package skel_pkg:
  - PIX_FG = 8'h01, PIX_BG = 8'h00.
  - loader_state_t enum {IDLE, LOAD, DONE}.
  - function is_border(row, col, N).
- Sub-module raster_counter(N): clk, rst, clr, inc; outputs row, col, index, last_pixel. The loader instantiates one.

Test Plan:
- N=8, start with threshold=128, 64 beats of 200 with s_last on beat 63 -> 64 writes at addr 0..63; 36 interior addresses = 8'h01, 28 border = 8'h00; frame_done coincides with the addr-63 write; err=0.
- Threshold edge: interior addr 9 with s_data=128, threshold=128 -> 8'h01; addr 10 with s_data=127 -> 8'h00; border addr 0 with s_data=255 -> 8'h00.
- Backpressure: s_valid high every other cycle -> writes only one cycle after accepted beats; addresses contiguous 0..63; exactly 64 mem_we pulses; frame ends at cycle ~128.
- Early s_last on beat 10 -> 11 writes (addr 0..10), frame_done pulse, err=1, s_ready=0 afterwards; the next start clears err.
- Missing s_last over 64 beats -> 64 writes, frame_done, err=1. A start pulse issued mid-LOAD is ignored (addr sequence unbroken).
- rst asserted after beat 20 -> all outputs 0 immediately, busy=0. A new start then reloads from addr 0 with no stale writes.

Source files
------------

// File: rtl/skel_pkg.sv
// skel_pkg: shared pixel codes, loader states and border test for the skeletonization datapath.
package skel_pkg;
    localparam logic [7:0] PIX_FG = 8'h01;
    localparam logic [7:0] PIX_BG = 8'h00;
    typedef enum logic [1:0] {IDLE, LOAD, DONE} loader_state_t;
    function automatic logic is_border(input int row, input int col, input int n);
        return row == 0 || col == 0 || row == n - 1 || col == n - 1;
    endfunction
endpackage

// File: rtl/raster_counter.sv
// raster_counter: row/col/linear index walker over an N x N raster, flags the final pixel.
module raster_counter #(
    parameter int N  = 8,
    parameter int AW = 7,
    parameter int RW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [RW-1:0] row,
    output logic [RW-1:0] col,
    output logic [AW-1:0] index,
    output logic          last_pixel
);
    logic [RW-1:0] row_q, row_d, col_q, col_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          col_wrap;
    assign col_wrap = col_q == RW'(N - 1);
    always_comb begin
        col_d = clr ? '0 : inc ? (col_wrap ? '0 : col_q + 1'b1) : col_q;
        row_d = clr ? '0 : (inc && col_wrap) ? row_q + 1'b1 : row_q;
        idx_d = clr ? '0 : inc ? idx_q + 1'b1 : idx_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
            idx_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
            idx_q <= idx_d;
        end
    end
    assign row        = row_q;
    assign col        = col_q;
    assign index      = idx_q;
    assign last_pixel = idx_q == AW'(N * N - 1);
endmodule

// File: rtl/image_loader.sv
// image_loader: binarizes a raster pixel stream against a latched threshold and writes it to image RAM,
// clearing the one-pixel border and flagging framing errors on s_last.
module image_loader
    import skel_pkg::*;
#(
    parameter int N            = 8,
    parameter int bitSize      = 6,
    parameter int BORDER_CLEAR = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       threshold,
    input  logic             s_valid,
    input  logic [7:0]       s_data,
    input  logic             s_last,
    output logic             s_ready,
    output logic             mem_we,
    output logic [bitSize:0] mem_addr,
    output logic [7:0]       mem_data,
    output logic             busy,
    output logic             frame_done,
    output logic             err
);
    localparam int RW = $clog2(N);
    loader_state_t    state_q, state_d;
    logic [7:0]       thr_q, thr_d, data_q, data_d, pix;
    logic             we_q, we_d, err_q, err_d, clr, xfer, final_beat, last_pixel;
    logic [bitSize:0] addr_q, addr_d, index;
    logic [RW-1:0]    row, col;

    raster_counter #(.N(N), .AW(bitSize + 1), .RW(RW)) u_cnt (
        .clk(clk), .rst(rst), .clr(clr), .inc(xfer),
        .row(row), .col(col), .index(index), .last_pixel(last_pixel)
    );

    assign s_ready    = state_q == LOAD;
    assign xfer       = s_valid && s_ready;
    // A frame ends on whichever comes first: the last raster slot or an s_last marker.
    assign final_beat = xfer && (last_pixel || s_last);
    assign pix = (BORDER_CLEAR != 0 && is_border(int'(row), int'(col), N)) ? PIX_BG :
                 (s_data >= thr_q) ? PIX_FG : PIX_BG;

    always_comb begin
        clr     = state_q == IDLE && start;
        thr_d   = clr ? threshold : thr_q;
        err_d   = clr ? 1'b0 : (final_beat && (last_pixel != s_last)) ? 1'b1 : err_q;
        we_d    = xfer;
        addr_d  = xfer ? index : addr_q;
        data_d  = xfer ? pix : data_q;
        state_d = state_q == IDLE ? (start ? LOAD : IDLE) :
                  state_q == LOAD ? (final_beat ? DONE : LOAD) : IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            thr_q   <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            thr_q   <= thr_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_data   = data_q;
    assign busy       = state_q != IDLE;
    assign frame_done = state_q == DONE;
    assign err        = err_q;
endmodule
